// File: rtl/conv1d_job_sequencer.sv
// Sequences one conv1d job: parameter programming, then set_x/start/poll/read per output, results on valid/ready.
// Optional CONV_SEQ_PERF_CNT_EN adds perf_cycles/perf_polls job counters.
module conv1d_job_sequencer #(
    parameter int INT32_SIZE         = 32,
    parameter int CMD_WIDTH          = 7,
    parameter int KERNEL_LENGTH      = 8,
    parameter int MAX_INPUT_CHANNELS = 128,
    parameter int MAX_WIDTH          = 1024,
    parameter int POLL_TIMEOUT       = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [INT32_SIZE-1:0] job_input_offset,
    input  logic [INT32_SIZE-1:0] job_input_depth,
    input  logic [INT32_SIZE-1:0] job_width,
    input  logic [INT32_SIZE-1:0] job_start_x,
    input  logic                  step_valid,
    output logic                  step_ready,
    output logic                  conv_en,
    output logic [CMD_WIDTH-1:0]  conv_cmd,
    output logic [INT32_SIZE-1:0] conv_inp0,
    output logic [INT32_SIZE-1:0] conv_inp1,
    input  logic [INT32_SIZE-1:0] conv_ret,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT32_SIZE-1:0] res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error
`ifdef CONV_SEQ_PERF_CNT_EN
    ,
    output logic [INT32_SIZE-1:0] perf_cycles,
    output logic [INT32_SIZE-1:0] perf_polls
`endif
);

    localparam int PW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_OFF, S_CFG_DEPTH, S_CFG_WIDTH, S_SET_X, S_START,
        S_POLL_ISSUE, S_POLL_WAIT, S_READ_ISSUE, S_READ_WAIT, S_PUSH, S_STEP, S_FIN
    } state_t;

    state_t                state, next;
    logic [INT32_SIZE-1:0] offset_q, depth_q, width_q, start_x_q, idx;
    logic [PW-1:0]         poll_cnt;
    logic [PW-1:0]         poll_next;
    logic [INT32_SIZE-1:0] ring_pos;
    logic                  job_bad, is_last, poll_expired;

    assign job_bad      = (job_input_depth == '0) ||
                          (job_input_depth > INT32_SIZE'(MAX_INPUT_CHANNELS)) ||
                          (job_width > INT32_SIZE'(MAX_WIDTH));
    assign poll_next    = poll_cnt + PW'(1);
    assign poll_expired = (poll_next == PW'(POLL_TIMEOUT));
    assign is_last      = (idx == width_q - INT32_SIZE'(1));
    assign ring_pos     = start_x_q + idx;

    assign job_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign conv_en    = busy;
    assign conv_inp0  = '0;
    assign res_valid  = (state == S_PUSH);
    assign res_last   = (state == S_PUSH) && is_last;
    assign step_ready = (state == S_STEP);
    assign done       = (state == S_FIN);

    always_comb begin
        next      = state;
        conv_cmd  = '0;
        conv_inp1 = '0;
        case (state)
            S_IDLE:       if (job_valid) next = (job_bad || job_width == '0) ? S_FIN : S_CFG_OFF;
            S_CFG_OFF:    begin conv_cmd = CMD_WIDTH'(3); conv_inp1 = offset_q; next = S_CFG_DEPTH; end
            S_CFG_DEPTH:  begin conv_cmd = CMD_WIDTH'(5); conv_inp1 = depth_q;  next = S_CFG_WIDTH; end
            S_CFG_WIDTH:  begin conv_cmd = CMD_WIDTH'(4); conv_inp1 = width_q;  next = S_SET_X; end
            S_SET_X: begin
                // KERNEL_LENGTH is a power of two, so the mask is the ring wrap
                conv_cmd  = CMD_WIDTH'(8);
                conv_inp1 = ring_pos & INT32_SIZE'(KERNEL_LENGTH - 1);
                next      = S_START;
            end
            S_START:      begin conv_cmd = CMD_WIDTH'(6); next = S_POLL_ISSUE; end
            S_POLL_ISSUE: begin conv_cmd = CMD_WIDTH'(9); next = S_POLL_WAIT; end
            S_POLL_WAIT: begin
                if (conv_ret[0])       next = S_READ_ISSUE;
                else if (poll_expired) next = S_FIN;
                else                   next = S_POLL_ISSUE;
            end
            S_READ_ISSUE: begin conv_cmd = CMD_WIDTH'(7); next = S_READ_WAIT; end
            S_READ_WAIT:  next = S_PUSH;
            S_PUSH:       if (res_ready) next = is_last ? S_FIN : S_STEP;
            S_STEP:       if (step_valid) next = S_SET_X;
            S_FIN:        next = S_IDLE;
            default:      next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            offset_q  <= '0;
            depth_q   <= '0;
            width_q   <= '0;
            start_x_q <= '0;
            idx       <= '0;
            poll_cnt  <= '0;
            res_data  <= '0;
            error     <= 1'b0;
        end else begin
            state <= next;
            case (state)
                S_IDLE: if (job_valid) begin
                    offset_q  <= job_input_offset;
                    depth_q   <= job_input_depth;
                    width_q   <= job_width;
                    start_x_q <= job_start_x;
                    idx       <= '0;
                    error     <= job_bad;
                end
                S_START:     poll_cnt <= '0;
                S_POLL_WAIT: if (!conv_ret[0]) begin
                    poll_cnt <= poll_next;
                    if (poll_expired) error <= 1'b1;
                end
                S_READ_WAIT: res_data <= conv_ret;
                S_STEP:      if (step_valid) idx <= idx + INT32_SIZE'(1);
                default: ;
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_CNT_EN
    logic [INT32_SIZE-1:0] cyc_run, poll_run;

    function automatic logic [INT32_SIZE-1:0] sat_inc(input logic [INT32_SIZE-1:0] v);
        return (&v) ? v : v + INT32_SIZE'(1);
    endfunction

    // Live counters run through the job; the visible outputs only update at the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_run     <= '0;
            poll_run    <= '0;
            perf_cycles <= '0;
            perf_polls  <= '0;
        end else if (state == S_IDLE) begin
            if (job_valid) begin
                cyc_run  <= '0;
                poll_run <= '0;
            end
        end else begin
            cyc_run <= sat_inc(cyc_run);
            if (state == S_POLL_ISSUE) poll_run <= sat_inc(poll_run);
            if (state == S_FIN) begin
                perf_cycles <= sat_inc(cyc_run);
                perf_polls  <= poll_run;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv1d_job_sequencer.sv
// Randomized bench for conv1d_job_sequencer with a behavioural conv1d and a job-level command/result model.
module tb_conv1d_job_sequencer;

    logic        clk, rst;
    logic        job_valid, job_ready;
    logic [31:0] job_input_offset, job_input_depth, job_width, job_start_x;
    logic        step_valid, step_ready;
    logic        conv_en;
    logic [6:0]  conv_cmd;
    logic [31:0] conv_inp0, conv_inp1, conv_ret;
    logic        res_valid, res_ready, res_last;
    logic [31:0] res_data;
    logic        busy, done, error;
`ifdef CONV_SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_polls;
`endif

    conv1d_job_sequencer dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_input_offset(job_input_offset), .job_input_depth(job_input_depth),
        .job_width(job_width), .job_start_x(job_start_x),
        .step_valid(step_valid), .step_ready(step_ready),
        .conv_en(conv_en), .conv_cmd(conv_cmd), .conv_inp0(conv_inp0),
        .conv_inp1(conv_inp1), .conv_ret(conv_ret),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .done(done), .error(error)
`ifdef CONV_SEQ_PERF_CNT_EN
        , .perf_cycles(perf_cycles), .perf_polls(perf_polls)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] acc_val(input logic [31:0] off, input logic [31:0] dep, input logic [31:0] x);
        return (off * 32'h9E37) ^ (dep << 12) ^ (x * 32'h01000193) ^ 32'h5A5A0000;
    endfunction

    // Behavioural conv1d: registered ret, finishes after 'need' polls (0 = never)
    int          need = 0;
    int          m_polls = 0;
    logic [31:0] m_off = 0, m_dep = 0, m_x = 0;
    always @(posedge clk) begin
        conv_ret <= $urandom;
        if (conv_en) begin
            case (conv_cmd)
                7'd3: m_off <= conv_inp1;
                7'd5: m_dep <= conv_inp1;
                7'd8: m_x <= conv_inp1;
                7'd6: m_polls <= 0;
                7'd9: begin
                    m_polls  <= m_polls + 1;
                    conv_ret <= ($urandom & ~32'h1) | ((need != 0 && m_polls + 1 >= need) ? 32'h1 : 32'h0);
                end
                7'd7: conv_ret <= acc_val(m_off, m_dep, m_x);
                default: ;
            endcase
        end
    end

    // Monitor
    logic [38:0] got_cmd[$];
    logic [32:0] got_res[$];
    int          done_cnt = 0;
    int          busy_cnt = 0;
    bit          stall_prev = 0;
    logic [31:0] prev_dat = 0;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (conv_en && conv_cmd != 0) begin
                got_cmd.push_back({conv_cmd, (conv_cmd inside {7'd3, 7'd4, 7'd5, 7'd8}) ? conv_inp1 : 32'h0});
                check("inp0", conv_inp0, 0);
            end
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (stall_prev) begin
                check("hold_vld", res_valid, 1);
                check("hold_dat", res_data, prev_dat);
            end
            if (res_valid) begin
                check("push_cmd", conv_cmd, 0);
                check("push_step_rdy", step_ready, 0);
            end
            if (res_valid && res_ready) got_res.push_back({res_last, res_data});
            stall_prev = res_valid && !res_ready;
            prev_dat   = res_data;
        end
    end

    bit force_stall = 0;
    initial begin
        res_ready  = 0;
        step_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            res_ready  = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            step_valid = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic start_job(input logic [31:0] off, input logic [31:0] dep, input logic [31:0] wid, input logic [31:0] sx);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        job_input_offset = off;
        job_input_depth  = dep;
        job_width        = wid;
        job_start_x      = sx;
        job_valid        = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (job_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1;
        job_valid = 0;
        check("accept", ok, 1);
    endtask

    task automatic run_job(input logic [31:0] off, input logic [31:0] dep, input logic [31:0] wid,
                           input logic [31:0] sx, input int polls);
        logic [38:0] exp_cmd[$];
        logic [32:0] exp_res[$];
        logic [31:0] x;
        bit          bad, exp_err, seen;
        int          cycles;
        bad     = (dep == 0) || (dep > 128) || (wid > 1024);
        exp_err = bad || (wid != 0 && polls == 0);
        if (!bad && wid != 0) begin
            exp_cmd.push_back({7'd3, off});
            exp_cmd.push_back({7'd5, dep});
            exp_cmd.push_back({7'd4, wid});
            for (int i = 0; i < int'(wid); i++) begin
                x = (sx + 32'(i)) % 8;
                exp_cmd.push_back({7'd8, x});
                exp_cmd.push_back({7'd6, 32'h0});
                if (polls == 0) begin
                    for (int p = 0; p < 256; p++) exp_cmd.push_back({7'd9, 32'h0});
                    break;
                end
                for (int p = 0; p < polls; p++) exp_cmd.push_back({7'd9, 32'h0});
                exp_cmd.push_back({7'd7, 32'h0});
                exp_res.push_back({i == int'(wid) - 1, acc_val(off, dep, x)});
            end
        end
        need = polls;
        got_cmd.delete();
        got_res.delete();
        done_cnt = 0;
        busy_cnt = 0;
        start_job(off, dep, wid, sx);
        seen   = 0;
        cycles = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            cycles++;
            if (done) begin seen = 1; break; end
        end
        check("done_seen", seen, 1);
        if (bad) check("bad_done_lat", cycles <= 2, 1);
        @(negedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("error", error, exp_err);
        check("job_ready_end", job_ready, 1);
        check("busy_end", busy, 0);
        check("n_cmds", got_cmd.size(), exp_cmd.size());
        for (int k = 0; k < exp_cmd.size() && k < got_cmd.size(); k++) check("cmd", got_cmd[k], exp_cmd[k]);
        check("n_res", got_res.size(), exp_res.size());
        for (int k = 0; k < exp_res.size() && k < got_res.size(); k++) check("res", got_res[k], exp_res[k]);
`ifdef CONV_SEQ_PERF_CNT_EN
        check("perf_cycles", perf_cycles, busy_cnt);
        check("perf_polls", perf_polls, exp_cmd.size() - (exp_cmd.size() == 0 ? 0 : 3) - 3 * exp_res.size()
              - ((polls == 0 && exp_cmd.size() != 0) ? 2 : 0));
`endif
    endtask

    task automatic stall_probe();
        bit          seen;
        logic [31:0] d0;
        seen = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1; break; end
        end
        check("stall_seen", seen, 1);
        d0 = res_data;
        for (int c = 0; c < 10; c++) begin
            check("stall_vld", res_valid, 1);
            check("stall_dat", res_data, d0);
            check("stall_cmd", conv_cmd, 0);
            check("stall_step", step_ready, 0);
            if (c != 9) @(negedge clk);
        end
        force_stall = 0;
    endtask

    initial begin
        bit seen9;
        rst = 1;
        job_valid = 0;
        job_input_offset = 0;
        job_input_depth = 0;
        job_width = 0;
        job_start_x = 0;
        repeat (2) @(negedge clk);
        check("rst_job_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_conv_en", conv_en, 0);
        check("rst_cmd", conv_cmd, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_step_ready", step_ready, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk);
        #1 rst = 0;

        run_job(128, 4, 3, 6, 2);
        run_job(5, 0, 3, 1, 1);
        run_job(5, 129, 3, 1, 1);
        run_job(5, 4, 1025, 1, 1);
        run_job(9, 4, 0, 3, 1);
        run_job(77, 16, 2, 7, 0);

        force_stall = 1;
        fork
            run_job(32'hDEAD, 8, 2, 3, 1);
            stall_probe();
        join

        // Reset while the sequencer waits on a poll result
        need = 0;
        start_job(1, 4, 2, 0);
        seen9 = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (conv_cmd == 7'd9) begin seen9 = 1; break; end
        end
        check("rst_mid_poll_seen", seen9, 1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("mid_rst_conv_en", conv_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_job_ready", job_ready, 1);
        @(posedge clk);
        #1 rst = 0;
        run_job(200, 3, 4, 5, 3);

        for (int j = 0; j < 25; j++) begin
            logic [31:0] dep, wid;
            int          r, polls;
            r = $urandom_range(0, 11);
            dep = (r == 0) ? 0 : (r == 1) ? 129 + $urandom_range(0, 1000) : $urandom_range(1, 128);
            r = $urandom_range(0, 11);
            wid = (r == 0) ? 1025 + $urandom_range(0, 50) : $urandom_range(0, 6);
            polls = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 4);
            run_job($urandom, dep, wid, $urandom, polls);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
